// File: rtl/fifo_packet_arbiter_if.sv
// Requester-side and downstream-side word handshake bundle
// for the two-way packet arbiter.
interface fifo_packet_arbiter_if;
  logic [1:0]  in_wr_en;
  logic [63:0] in_data0;
  logic [63:0] in_data1;
  logic [1:0]  in_last;
  logic [1:0]  in_full;
  logic        out_wr_en;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_full;

  modport master (
    output in_wr_en, in_data0, in_data1,
    output in_last, out_full,
    input  in_full, out_wr_en, out_data,
    input  out_last
  );

  modport slave (
    input  in_wr_en, in_data0, in_data1,
    input  in_last, out_full,
    output in_full, out_wr_en, out_data,
    output out_last
  );
endinterface

// File: rtl/fifo_packet_arbiter.sv
// Two requester packet buffers merged into one downstream
// FIFO write port, whole packets at a time.
module fifo_packet_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_packet_arbiter_if.slave  bus,
  input  logic                  clear_stats,
  output logic [1:0]            grant,
  output logic [31:0]           packets_forwarded,
  output logic [15:0]           drop_count,
  output logic [1:0]            overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  word_t         mem [2][DEPTH];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [AW:0]   cnt  [2];

  state_t state, state_n;
  logic   last_gnt;

  logic [1:0] full, nonempty, acc, drop;
  logic [1:0] popv;
  word_t      in_word [2];
  word_t      head;
  logic       sel, pop;

  logic        owr_q, olast_q;
  logic [63:0] odata_q;

  logic [1:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (cnt[i] == FULL_CNT);
      nonempty[i] = (cnt[i] != '0);
      acc[i]      = bus.in_wr_en[i] & ~full[i] & ~rst;
      drop[i]     = bus.in_wr_en[i] & full[i] & ~rst;
    end
    in_word[0] = '{last: bus.in_last[0], data: bus.in_data0};
    in_word[1] = '{last: bus.in_last[1], data: bus.in_data1};
  end

  assign bus.in_full = full;

  always_comb begin
    sel  = (state == OWN1);
    head = mem[sel][rptr[sel]];
    pop  = (state != IDLE) & nonempty[sel] & ~bus.out_full;
    popv = 2'b00;
    if (pop) popv = sel ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (nonempty == 2'b11): state_n = last_gnt ? OWN0 : OWN1;
          (nonempty == 2'b01): state_n = OWN0;
          (nonempty == 2'b10): state_n = OWN1;
          default:             state_n = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        // Ownership ends only on a popped last word.
        if (pop && head.last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant = {state == OWN1, state == OWN0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE)
        last_gnt <= (state_n == OWN1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) mem[i][wptr[i]] <= in_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i])  wptr[i] <= wptr[i] + AW'(1);
        if (popv[i]) rptr[i] <= rptr[i] + AW'(1);
        cnt[i] <= cnt[i] + (AW+1)'(acc[i]) - (AW+1)'(popv[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owr_q   <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
    end else begin
      owr_q <= pop;
      if (pop) begin
        olast_q <= head.last;
        odata_q <= head.data;
      end
    end
  end

  assign bus.out_wr_en = owr_q;
  assign bus.out_data  = odata_q;
  assign bus.out_last  = olast_q;

  // Both requesters can drop in the same cycle.
  assign drop_n   = {1'b0, drop[0]} + {1'b0, drop[1]};
  assign drop_sum = {1'b0, drop_count} + {15'b0, drop_n};

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      packets_forwarded <= '0;
      drop_count        <= '0;
      overflow          <= '0;
    end else begin
      if (owr_q && olast_q)
        packets_forwarded <= packets_forwarded + 32'd1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow   <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_fifo_packet_arbiter.sv
// Directed bench for fifo_packet_arbiter: ordering,
// arbitration, backpressure, overflow and reset.
module tb_fifo_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_stats;
  logic [1:0]  grant;
  logic [31:0] packets_forwarded;
  logic [15:0] drop_count;
  logic [1:0]  overflow;

  fifo_packet_arbiter_if bus();

  fifo_packet_arbiter #(.DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .clear_stats       (clear_stats),
    .grant             (grant),
    .packets_forwarded (packets_forwarded),
    .drop_count        (drop_count),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int snap;

  logic [64:0] q [$];
  logic [64:0] e [$];

  always @(negedge clk)
    if (bus.out_wr_en) q.push_back({bus.out_last, bus.out_data});

  task automatic chk(input string tag,
                     input logic [64:0] got,
                     input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.in_wr_en = 2'b00;
    bus.in_last  = 2'b00;
  endtask

  task automatic wr(input int r, input logic [63:0] d,
                    input logic l);
    bus.in_wr_en[r] = 1'b1;
    bus.in_last[r]  = l;
    if (r == 0) bus.in_data0 = d;
    else        bus.in_data1 = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_in;
    step;
    rst = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input string tag);
    int n = 0;
    while (packets_forwarded < target && n < 200) begin
      step;
      n++;
    end
    chk(tag, packets_forwarded, target);
  endtask

  task automatic check_q(input string tag);
    chk($sformatf("%s_cnt", tag), q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < q.size())
        chk($sformatf("%s_w%0d", tag, i), q[i], e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    clear_stats  = 1'b0;
    bus.out_full = 1'b0;
    bus.in_data0 = '0;
    bus.in_data1 = '0;
    idle_in;
    step;

    // reset state and single-requester packet
    do_reset;
    chk("rst_grant", grant, 2'b00);
    chk("rst_owr", bus.out_wr_en, 1'b0);
    chk("rst_odata", bus.out_data, 64'h0);
    chk("rst_olast", bus.out_last, 1'b0);
    chk("rst_infull", bus.in_full, 2'b00);
    chk("rst_pkts", packets_forwarded, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 2'b00);
    q.delete();
    e.delete();
    for (int i = 0; i < 37; i++) begin
      idle_in;
      wr(0, 64'h1000 + i, i == 36);
      e.push_back({i == 36, 64'h1000 + i});
      if (i == 2) chk("t1_grant", grant, 2'b01);
      step;
    end
    idle_in;
    wait_pkts(1, "t1_pkts");
    chk("t1_idle", grant, 2'b00);
    check_q("t1");

    // contention alternates 0,1,0,1
    do_reset;
    q.delete();
    e.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        idle_in;
        wr(0, 64'hA000 + 16 * r + k, k == 2);
        wr(1, 64'hB000 + 16 * r + k, k == 2);
        step;
      end
      idle_in;
      for (int k = 0; k < 3; k++)
        e.push_back({k == 2, 64'hA000 + 16 * r + k});
      for (int k = 0; k < 3; k++)
        e.push_back({k == 2, 64'hB000 + 16 * r + k});
      wait_pkts(2 * (r + 1), $sformatf("t2_pkts%0d", r));
    end
    check_q("t2");

    // owner starved mid-packet keeps grant
    do_reset;
    q.delete();
    e.delete();
    for (int c = 0; c < 13; c++) begin
      idle_in;
      if (c < 3) wr(0, 64'hC000 + c, 1'b0);
      if (c >= 3 && c < 5) wr(1, 64'hD000 + c - 3, c == 4);
      if (c >= 3) chk($sformatf("t3_hold%0d", c), grant, 2'b01);
      step;
    end
    for (int c = 0; c < 2; c++) begin
      idle_in;
      wr(0, 64'hC003 + c, c == 1);
      step;
    end
    idle_in;
    for (int k = 0; k < 5; k++) e.push_back({k == 4, 64'hC000 + k});
    for (int k = 0; k < 2; k++) e.push_back({k == 1, 64'hD000 + k});
    wait_pkts(2, "t3_pkts");
    check_q("t3");

    // backpressure mid-packet
    do_reset;
    q.delete();
    e.delete();
    snap = 0;
    for (int c = 0; c < 10; c++) begin
      idle_in;
      if (c < 8) begin
        wr(0, 64'hE000 + c, c == 7);
        e.push_back({c == 7, 64'hE000 + c});
      end
      if (c == 4) begin
        bus.out_full = 1'b1;
        snap = q.size();
      end
      if (c == 9) begin
        chk("t4_bp", (q.size() - snap) <= 1, 1'b1);
        bus.out_full = 1'b0;
      end
      step;
    end
    idle_in;
    wait_pkts(1, "t4_pkts");
    check_q("t4");

    // overflow, drop counting and clear_stats
    do_reset;
    bus.out_full = 1'b1;
    for (int c = 0; c < 11; c++) begin
      idle_in;
      wr(1, 64'hF000 + c, c == 10);
      step;
    end
    idle_in;
    chk("t5_infull", bus.in_full, 2'b10);
    chk("t5_drop", drop_count, 3);
    chk("t5_ovf", overflow, 2'b10);
    clear_stats = 1'b1;
    step;
    clear_stats = 1'b0;
    chk("t5_clr_drop", drop_count, 0);
    chk("t5_clr_ovf", overflow, 2'b00);

    // reset mid-packet, then a clean packet
    bus.out_full = 1'b0;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      idle_in;
      wr(0, 64'h5000 + c, 1'b0);
      if (c == 4) rst = 1'b1;
      step;
    end
    rst = 1'b0;
    idle_in;
    chk("t6_grant", grant, 2'b00);
    chk("t6_owr", bus.out_wr_en, 1'b0);
    chk("t6_odata", bus.out_data, 64'h0);
    chk("t6_olast", bus.out_last, 1'b0);
    chk("t6_infull", bus.in_full, 2'b00);
    chk("t6_pkts", packets_forwarded, 0);
    q.delete();
    e.delete();
    for (int c = 0; c < 4; c++) begin
      idle_in;
      wr(0, 64'h6000 + c, c == 3);
      e.push_back({c == 3, 64'h6000 + c});
      step;
    end
    idle_in;
    wait_pkts(1, "t6_after");
    repeat (3) step;
    check_q("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_packet_arbiter.md
FIFO_PACKET_ARBITER -- requirements
Module: fifo_packet_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, per-requester buffer depth in 64-bit words (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_wr_en[1:0]  input  2  per-requester word write strobe (requester 0 = bit 0).
REQ-005 SHALL have ports in_data0, in_data1  input  64 each  requester write data.
REQ-006 SHALL have ports in_last[1:0]  input  2  per-requester flag: word ends its packet.
REQ-007 SHALL have ports in_full[1:0]  output  2  per-requester buffer full (count == DEPTH).
REQ-008 SHALL have port out_wr_en  output  1  downstream FIFO write strobe.
REQ-009 SHALL have port out_data  output  64  downstream write data.
REQ-010 SHALL have port out_last  output  1  packet-end flag accompanying out_data.
REQ-011 SHALL have port out_full  input  1  downstream almost-full; asserted while at least 1 free entry remains.
REQ-012 SHALL have port clear_stats  input  1  one-cycle pulse that zeroes the status counters.
REQ-013 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-014 SHALL have port packets_forwarded  output  32  count of out_last words written.
REQ-015 SHALL have port drop_count  output  16  saturating count of rejected input words.
REQ-016 SHALL have port overflow  output  2  sticky per-requester drop flag.

Function
REQ-017 SHALL keep a DEPTH-entry buffer per requester holding {last, data}, with a registered occupancy count of width clog2(DEPTH)+1.
REQ-018 SHALL accept an input word only when in_wr_en[i]=1 and in_full[i]=0 in the same cycle; a same-cycle pop does not make room for it.
REQ-019 SHALL discard a word written while in_full[i]=1, set overflow[i], and increment drop_count, saturating at 16'hFFFF.
REQ-020 SHALL use FSM states IDLE, OWN0 and OWN1, with grant = 00, 01 and 10 respectively.
REQ-021 IDLE: if exactly one buffer is non-empty, move to its OWN state next cycle; if both are non-empty, take the requester not most recently granted (requester 0 after reset).
REQ-022 OWNi: pop one word each cycle while buffer i is non-empty and out_full=0; otherwise hold the grant and pop nothing.
REQ-023 OWNi SHALL hold ownership until the popped word has last=1; the next cycle is IDLE, and ownership is never taken mid-packet, even if buffer i is empty.
REQ-024 SHALL register output: a pop in cycle N drives out_wr_en=1, out_data and out_last in cycle N+1; out_wr_en=0 in all other cycles.
REQ-025 SHALL NOT pop in a cycle where out_full=1; the single in-flight write is absorbed by the downstream slack required in REQ-011.
REQ-026 SHALL increment packets_forwarded (wrapping at 2^32) in each cycle out_wr_en=1 and out_last=1.
REQ-027 clear_stats SHALL zero packets_forwarded, drop_count and overflow next cycle, and SHALL take priority over a same-cycle increment or set.
REQ-028 SHALL use wrapping read and write pointers modulo DEPTH; empty is count==0 and full is count==DEPTH.
REQ-029 Minimum IDLE dwell between packets SHALL be 1 cycle, so 1 packet end plus 1 IDLE cycle occurs before the next grant.

Reset
REQ-030 On rst=1, next cycle: state IDLE, grant=00, last-granted=1 (so requester 0 wins first), both buffers empty, in_full=00, out_wr_en=0, out_data=0, out_last=0, all counters and overflow zero.
REQ-031 rst asserted mid-packet SHALL flush the partial packet without emitting a trailing write; inputs presented during rst are ignored.

Verification
REQ-032 Single requester: req0 writes 37 words, last on word 37, out_full=0 -> grant=01 from cycle 2, 37 out writes in order, out_last only on write 37, packets_forwarded=1, then grant=00.
REQ-033 Contention: both buffers non-empty in the same cycle after reset -> req0 packet first, then req1; repeat -> order alternates 0,1,0,1.
REQ-034 Mid-packet starvation: req0 sends 3 of 5 words, pauses 10 cycles while req1 has data -> grant stays 01, no req1 words interleaved.
REQ-035 Backpressure: out_full=1 for 5 cycles mid-packet -> no pops while asserted, at most 1 write after assertion, no words lost or duplicated.
REQ-036 Overflow: out_full=1, req1 writes DEPTH+3 words -> in_full[1]=1, drop_count=3, overflow=10; clear_stats -> both zero next cycle.
REQ-037 Reset mid-packet: rst for 1 cycle during req0 packet -> all outputs at reset values, first post-reset packet forwarded intact.
